// File: rtl/bit_set_gen_pkg.sv
// Shared types and helpers for the bit-set generator: FSM state encoding,
// datapath select codes and the count-register width function.
package bit_set_gen_pkg;

    typedef enum logic [1:0] {
        START   = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam logic WORK_CLEAR = 1'b0;
    localparam logic WORK_SHIFT = 1'b1;
    localparam logic COUNT_LOAD = 1'b0;
    localparam logic COUNT_DEC  = 1'b1;

    // Bits needed to hold any count from 0 up to and including width.
    function automatic int COUNT_WIDTH(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_set_gen_datapath.sv
// Datapath for the bit-set generator: clamp of the requested count, shifting
// work register, decrementing count register and the result register.
module bit_set_gen_datapath
    import bit_set_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = COUNT_WIDTH(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW-1:0]    in_k,
    input  logic             work_sel,
    input  logic             work_en,
    input  logic             count_sel,
    input  logic             count_en,
    input  logic             out_en,
    output logic [WIDTH-1:0] out_word,
    output logic             count_done
);

    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] work_nx_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nx_s;
    logic [CW-1:0]    clamp_s;
    logic [WIDTH-1:0] out_r;

    assign count_done = (count_r == {CW{1'b0}});
    assign out_word   = out_r;

    // Clamp the request to WIDTH so the shifter can never run past the MSB.
    always_comb begin
        clamp_s = in_k;
        if (in_k > CW'(WIDTH)) begin
            clamp_s = CW'(WIDTH);
        end else begin
            clamp_s = in_k;
        end
    end

    // Next value of the work register: cleared on start, else shift a 1 in.
    always_comb begin
        work_nx_s = work_r;
        case (work_sel)
            WORK_CLEAR: work_nx_s = {WIDTH{1'b0}};
            WORK_SHIFT: work_nx_s = {work_r[WIDTH-2:0], 1'b1};
            default:    work_nx_s = {WIDTH{1'b0}};
        endcase
    end

    // Next value of the count register; the decrement saturates at zero.
    always_comb begin
        count_nx_s = count_r;
        case (count_sel)
            COUNT_LOAD: count_nx_s = clamp_s;
            COUNT_DEC: begin
                if (count_done) begin
                    count_nx_s = count_r;
                end else begin
                    count_nx_s = count_r - CW'(1);
                end
            end
            default:    count_nx_s = clamp_s;
        endcase
    end

    // Datapath registers, each updated only under its enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_r  <= {WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
            out_r   <= {WIDTH{1'b0}};
        end else begin
            if (work_en) begin
                work_r <= work_nx_s;
            end
            if (count_en) begin
                count_r <= count_nx_s;
            end
            if (out_en) begin
                out_r <= work_r;
            end
        end
    end

endmodule

// File: rtl/bit_set_gen.sv
// Bit-set generator: on go, produces a word with the k LSBs set by shifting
// ones in serially; FSM here, registers and arithmetic in the datapath.
module bit_set_gen
    import bit_set_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    input  logic [$clog2(WIDTH+1)-1:0] in,
    output logic [WIDTH-1:0]           out,
    output logic                       done
);

    localparam int CW = COUNT_WIDTH(WIDTH);

    state_e state_r;
    state_e state_nx_s;
    logic   done_r;
    logic   work_sel_s;
    logic   work_en_s;
    logic   count_sel_s;
    logic   count_en_s;
    logic   out_en_s;
    logic   count_done_s;

    // Next-state and datapath control decode.
    always_comb begin
        state_nx_s  = state_r;
        work_sel_s  = WORK_CLEAR;
        work_en_s   = 1'b0;
        count_sel_s = COUNT_LOAD;
        count_en_s  = 1'b0;
        out_en_s    = 1'b0;
        case (state_r)
            START, DONE: begin
                if (go) begin
                    state_nx_s = COMPUTE;
                    work_en_s  = 1'b1;
                    count_en_s = 1'b1;
                end else begin
                    state_nx_s = state_r;
                end
            end
            COMPUTE: begin
                if (count_done_s) begin
                    out_en_s   = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    work_sel_s  = WORK_SHIFT;
                    work_en_s   = 1'b1;
                    count_sel_s = COUNT_DEC;
                    count_en_s  = 1'b1;
                    state_nx_s  = COMPUTE;
                end
            end
            default: begin
                state_nx_s = START;
            end
        endcase
    end

    // State and done register; done is high exactly while the FSM sits in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= START;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            done_r  <= (state_nx_s == DONE);
        end
    end

    assign done = done_r;

    bit_set_gen_datapath #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .in_k       (in),
        .work_sel   (work_sel_s),
        .work_en    (work_en_s),
        .count_sel  (count_sel_s),
        .count_en   (count_en_s),
        .out_en     (out_en_s),
        .out_word   (out),
        .count_done (count_done_s)
    );

endmodule

// File: doc/bit_set_gen.md
BIT_SET_GEN -- requirements
Module: bit_set_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the output word width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (rst = 0 resets).
REQ-004 SHALL have port go, input, 1 bit: start request, sampled only in state START and state DONE.
REQ-005 SHALL have port in, input, $clog2(WIDTH+1) bits: requested number of asserted bits k.
REQ-006 SHALL have port out, output, WIDTH bits: generated word with the k LSBs set and all other bits clear.
REQ-007 SHALL have port done, output, 1 bit: out holds a valid result for the most recent accepted request.

Function
REQ-008 SHALL be the inverse of the team's bit counter: for an accepted k, out = (2^k)-1, and popcount(out) = min(k, WIDTH).
REQ-009 SHALL implement an FSM with states START, COMPUTE and DONE.
REQ-010 SHALL, in START or DONE with go = 1, capture min(in, WIDTH) into a count register, clear the work register, drive done = 0 and move to COMPUTE on the same edge.
REQ-011 SHALL, in COMPUTE with count register != 0, shift the work register left by one with LSB = 1 and decrement the count register by 1, staying in COMPUTE.
REQ-012 SHALL, in COMPUTE with count register = 0, load out from the work register and move to DONE.
REQ-013 SHALL assert done exactly while in DONE; done is a registered output, high k+1 cycles after the go-sampling edge (k = 0: 1 cycle).
REQ-014 SHALL hold out and done = 1 in DONE while go = 0; a new go in DONE restarts per REQ-010.
REQ-015 SHALL change out only on the completion edge (REQ-012); out keeps its previous result through START and COMPUTE.
REQ-016 SHALL ignore go and in while in COMPUTE; a changing in mid-operation has no effect on the result.
REQ-017 SHALL clamp in values greater than WIDTH to WIDTH (out = all ones); there is no error output.
REQ-018 SHALL never shift a 1 beyond bit WIDTH-1. The count register is $clog2(WIDTH+1) bits wide, and it never wraps below 0.

Reset
REQ-019 SHALL, while rst = 0 and regardless of the clock, force state = START, out = 0, done = 0, work register = 0 and count register = 0.
REQ-020 SHALL abandon any in-progress operation on reset without producing a done pulse.
REQ-021 SHALL ignore go sampled on the first rising edge after rst deasserts only if rst was still low at that edge; otherwise go is accepted normally.

Structure
REQ-022 SHALL place the state enum type (START, COMPUTE, DONE) in a shared package, bit_set_gen_pkg, with a COUNT_WIDTH(WIDTH) helper constant function.
REQ-023 SHALL split into the FSM at top level and one sub-module, bit_set_gen_datapath, holding the work, count and out registers, the clamp, shift and decrement logic, and the count = 0 comparator.
REQ-024 SHALL connect datapath and FSM with select and enable signals (work_sel, work_en, count_sel, count_en, out_en) plus one status signal, count_done.

Verification (WIDTH = 8)
REQ-025 SHALL test reset then go = 1 with in = 0: done rises 1 cycle later with out = 0x00.
REQ-026 SHALL test in = 3: done rises 4 cycles after go is sampled, out = 0x07, and done and out hold while go = 0.
REQ-027 SHALL test in = 8 and then in = 15: each gives out = 0xFF with done 9 cycles after go.
REQ-028 SHALL test in = 5 with in changed to 1 and go pulsed during COMPUTE: result is still out = 0x1F after 6 cycles, and no restart occurs.
REQ-029 SHALL test in = 6 with rst pulsed low at cycle 3: out = 0 and done = 0 immediately, state is START, and a following request with in = 2 gives 0x03.
REQ-030 SHALL run a round-trip over all k in 0..8: feed out into the team bit-counter datapath, whose count output must equal k.
